// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and constants for the PLL lock sequencer
package pll_seq_pkg;

  localparam int LOSS_CNT_W  = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    RUN,
    LOST
  } seq_state_e;

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - divisor load and reset/clock-enable output bundle
interface pll_lock_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
);
  import pll_seq_pkg::*;

  logic [NUM_CH*DIV_W-1:0] div_val;
  logic                    div_load;
  logic                    rst_out_n;
  logic                    locked;
  logic [NUM_CH-1:0]       ce_out;
  logic [LOSS_CNT_W-1:0]   loss_cnt;

  modport master (
    output div_val, div_load,
    input  rst_out_n, locked, ce_out, loss_cnt
  );

  modport slave (
    input  div_val, div_load,
    output rst_out_n, locked, ce_out, loss_cnt
  );

endinterface

// File: rtl/pll_seq_ce_div.sv
// rtl/pll_seq_ce_div.sv - single-channel clock-enable divider with shadowed divisor
module pll_seq_ce_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             ce_q, ce_d;

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ce_d     = 1'b0;
    if (en_i) begin
      if (cnt_q == div_q) begin
        cnt_d = '0;
        ce_d  = 1'b1;
        if (pend_v_q) begin
          div_d    = pend_q;
          pend_v_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
    // A value left pending when RUN ends is applied as soon as we are out of RUN.
    if (!run_i && pend_v_q) begin
      div_d    = pend_q;
      pend_v_d = 1'b0;
    end
    if (load_i) begin
      if (run_i) begin
        pend_d   = div_i;
        pend_v_d = 1'b1;
      end else begin
        div_d    = div_i;
        pend_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      div_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ce_q     <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL lock qualifier, reset release and CE dividers; PLL_SEQ_LOSS_CNT_EN builds the loss counter
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DIV_W         = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_FILT     = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               pll_lock,
  pll_lock_sequencer_if.slave bus
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam int FILT_W = $clog2(LOCK_FILT + 1);

  seq_state_e             state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [STAB_W-1:0]      stab_q;
  logic [FILT_W-1:0]      filt_q;
  logic                   rst_out_q;
  logic                   locked_q;
  logic                   lock_s;
  logic                   filt_hit;
  logic                   run;
  logic                   div_en;
  logic [NUM_CH-1:0]      ce;

  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign filt_hit = (filt_q == FILT_W'(LOCK_FILT));
  assign run      = (state_q == RUN);
  // Dividers stop on the same edge that leaves RUN so no strobe escapes into LOST.
  assign div_en   = run && !filt_hit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= WAIT_LOCK;
      stab_q    <= '0;
      filt_q    <= '0;
      rst_out_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABILIZE;
            stab_q  <= '0;
          end
        end
        STABILIZE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
          end else if (stab_q == STAB_W'(STABLE_CYCLES - 1)) begin
            state_q   <= RUN;
            filt_q    <= '0;
            rst_out_q <= 1'b1;
            locked_q  <= 1'b1;
          end else begin
            stab_q <= stab_q + 1'b1;
          end
        end
        RUN: begin
          if (filt_hit) begin
            state_q   <= LOST;
            rst_out_q <= 1'b0;
            locked_q  <= 1'b0;
          end else if (lock_s) begin
            filt_q <= '0;
          end else begin
            filt_q <= filt_q + 1'b1;
          end
        end
        LOST: begin
          state_q <= WAIT_LOCK;
        end
        default: begin
          state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_seq_ce_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .run_i  (run),
      .en_i   (div_en),
      .load_i (bus.div_load),
      .div_i  (bus.div_val[i*DIV_W +: DIV_W]),
      .ce_o   (ce[i])
    );
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      loss_cnt_q <= '0;
    end else if (run && filt_hit && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign bus.loss_cnt = loss_cnt_q;
`else
  assign bus.loss_cnt = '0;
`endif

  assign bus.rst_out_n = rst_out_q;
  assign bus.locked    = locked_q;
  assign bus.ce_out    = ce;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Parametrised clock-domain sequencer that sits directly behind the iCE40 PLL and its global buffer, in the `sys_clk` domain. It qualifies the PLL lock indication and holds the downstream reset until lock has been stable for a programmable time. It then generates NUM_CH independently divided clock-enable strobes for slower logic, so no extra PLL outputs or global buffers are needed. On loss of lock it re-asserts reset immediately and re-runs the sequence.

## Interface
- NUM_CH, 2: number of clock-enable channels (1..8)
- DIV_W, 16: divisor width per channel
- STABLE_CYCLES, 1024: consecutive locked cycles required before release (≥2)
- LOCK_FILT, 4: consecutive unlocked cycles that count as lock loss (≥1)

- sys_clk  in  1  PLL output via global buffer; only clock
- sys_rst_n  in  1  asynchronous, active-low reset
- pll_lock  in  1  raw PLL LOCK, asynchronous to sys_clk
- div_val  in  NUM_CH*DIV_W  per-channel divisor; channel i at [i*DIV_W +: DIV_W]
- div_load  in  1  one-cycle strobe; captures div_val into shadow registers
- rst_out_n  out  1  downstream active-low reset, registered
- locked  out  1  high while in RUN
- ce_out  out  NUM_CH  per-channel clock-enable strobes, registered
- loss_cnt  out  8  lock-loss count; see Configuration

## Operation
- pll_lock passes through a 2-FF synchroniser. lock_s is the synchronised value.
- FSM states: WAIT_LOCK, STABILIZE, RUN, LOST. Reset state is WAIT_LOCK.
- WAIT_LOCK: when lock_s=1, go to STABILIZE and clear stab_cnt.
- STABILIZE: stab_cnt increments while lock_s=1.
  - Any lock_s=0 returns the FSM to WAIT_LOCK. No filtering applies here.
  - At stab_cnt==STABLE_CYCLES-1, go to RUN.
- RUN: rst_out_n=1, locked=1, and the dividers run.
  - filt_cnt counts consecutive lock_s=0 cycles and clears whenever lock_s=1.
  - When filt_cnt reaches LOCK_FILT, go to LOST.
  - A dropout shorter than LOCK_FILT cycles is ignored.
- LOST: lasts one cycle. rst_out_n=0, dividers cleared, loss counter incremented, then WAIT_LOCK.
- Divider for channel i:
  - cnt_i clears on RUN entry.
  - ce_out[i]=1 on the cycle after cnt_i==div_i.
  - cnt_i wraps to 0 on match, otherwise increments.
  - Period is div_i+1 cycles with a single-cycle pulse. div_i=0 gives ce_out[i] constantly 1 in RUN.
- Shadow registers:
  - div_load outside RUN: all div_i load immediately.
  - div_load in RUN: the new value is held pending. Each channel adopts it at its own next wrap, so there is no short or long pulse.
  - A second div_load before adoption overwrites the pending value.
- Outside RUN, ce_out=0, locked=0, rst_out_n=0.
- Reset values: rst_out_n=0, locked=0, ce_out=0, loss_cnt=0, all div_i=0, no pending load.
- sys_rst_n asserted mid-operation: all state returns to reset values asynchronously. Deassertion is assumed synchronised upstream.

## Timing
- pll_lock rise to rst_out_n rise: 2 synchroniser cycles + 1 (WAIT_LOCK) + STABLE_CYCLES cycles.
  - With STABLE_CYCLES=16, rst_out_n rises 19 cycles after the first sys_clk edge sampling pll_lock=1.
- pll_lock fall in RUN to rst_out_n fall: 2 + LOCK_FILT + 1 cycles (LOST is registered).
- rst_out_n and locked change on the same edge.
- First ce_out[i] pulse occurs div_i+1 cycles after rst_out_n rises.
- div_load and lock loss on the same cycle: lock loss wins. The shadow load still happens, because the FSM is not in RUN on the next cycle.

## Configuration
- PLL_SEQ_LOSS_CNT_EN:
  - Defined: loss_cnt is an 8-bit counter, incremented on each LOST entry, saturating at 255, cleared only by sys_rst_n.
  - Undefined: the counter is not built and loss_cnt is tied to 0.

## Structure
- Shared package pll_seq_pkg holds:
  - the state enum (WAIT_LOCK, STABILIZE, RUN, LOST)
  - LOSS_CNT_W=8
  - the synchroniser depth constant SYNC_STAGES=2
- One sub-module, pll_seq_ce_div: a single-channel divider with shadow register, instantiated NUM_CH times by a generate loop. FSM, synchroniser and filter stay in the top module.

## Test plan
Defaults for all scenarios: NUM_CH=2, STABLE_CYCLES=16, LOCK_FILT=4.
1. Reset, pll_lock=1 held → rst_out_n and locked rise exactly 19 cycles after the first sampling edge; ce_out=0 before that.
2. pll_lock high for 10 cycles, low for 1, then high → no release at cycle 19; release 19 cycles after the re-rise.
3. In RUN, div=0 and 3 loaded → ce_out[0] constantly 1; ce_out[1] pulses every 4 cycles, first pulse 4 cycles after release.
4. In RUN, 3-cycle pll_lock dropout → no change to any output. A 4-cycle dropout → rst_out_n falls 7 cycles after the fall, and loss_cnt=1 with the macro defined.
5. In RUN, div_load changes channel 1 from 3 to 1 mid-period → remaining pulses at period 4 until the wrap, then period 2, with no runt pulse.
6. sys_rst_n pulsed low mid-RUN → all outputs are at reset values asynchronously, and the full sequence repeats.
